rc4_job_arbiter: RTL and testbench

Shares one rc4_new_design keystream core between NUM_REQ requesters.
- Arbitrates requests round-robin and latches the winner's key.
- Restarts and runs the core, waits for done, then returns the keystream block tagged with the requester id.
- Sits between the client ports and the single RC4 core; owns the core's start, key, key_length and per-job reset.

---
 rtl/rc4_job_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_rc4_job_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_job_arbiter.sv
// ---------------------------------------------------------------------------
// rc4_job_arbiter
//
// Shares a single RC4 keystream core between NUM_REQ requesters. Requests are
// arbitrated round-robin; the winner's key and key length are latched and
// driven to the core. The core is given a one-cycle reset and then started.
// On the rising edge of core_done, its keystream block is returned to the
// consumer, tagged with the requester id.
//
// Flow: IDLE -> GRANT -> CLR -> RUN -> RESP -> IDLE.
// A key length of 0 or greater than NUMS_OF_BYTES goes straight from IDLE to
// RESP with rsp_err=1. In that case the core is left untouched.
//
// Optional feature (compile-time macro RC4_ARB_WATCHDOG_EN):
//   When this macro is defined, a RUN-state watchdog aborts the job after
//   TIMEOUT_CYCLES cycles. It then reports rsp_err=1 with zero data and
//   pulses core_rst_n low for one cycle.
//   When the macro is undefined, RUN waits for core_done indefinitely.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req               per-requester request level (held until gnt)
//   req_key           requester r key at [r*NB*8 +: NB*8]
//   req_key_length    requester r key length at [r*8 +: 8]
//   gnt               one-hot accept pulse, high for the single GRANT cycle
//   rsp_valid/ready   response handshake
//   rsp_id            requester index of the response
//   rsp_err           job rejected or aborted (rsp_data is then zero)
//   rsp_data          keystream block, byte i at [i*8 +: 8]
//   busy              high whenever the FSM is not in IDLE
//   core_*            control and data interface of the shared RC4 core
// ---------------------------------------------------------------------------
module rc4_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUMS_OF_BYTES  = 16,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*NUMS_OF_BYTES*8-1:0] req_key,
    input  logic [NUM_REQ*8-1:0]              req_key_length,
    output logic [NUM_REQ-1:0]                gnt,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ID_W-1:0]                   rsp_id,
    output logic                              rsp_err,
    output logic [NUMS_OF_BYTES*8-1:0]        rsp_data,
    output logic                              busy,
    output logic                              core_rst_n,
    output logic                              core_start,
    output logic [NUMS_OF_BYTES*8-1:0]        core_key,
    output logic [7:0]                        core_key_length,
    input  logic [NUMS_OF_BYTES*8-1:0]        core_data_out,
    input  logic                              core_done
);

    localparam int KEY_W = NUMS_OF_BYTES * 8;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        CLR   = 3'd2,
        RUN   = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic             core_done_q;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] nxt_ptr;
    logic [KEY_W-1:0] win_key;
    logic [7:0]       win_len;
    logic             len_bad;
    logic             done_rise;

`ifdef RC4_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]  wd_cnt;
`endif

    // Round-robin search: the first set request at or above rr_ptr, wrapping.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && req[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        win_key   = req_key[int'(win_idx)*KEY_W +: KEY_W];
        win_len   = req_key_length[int'(win_idx)*8 +: 8];
        len_bad   = (win_len == 8'd0) || (int'(win_len) > NUMS_OF_BYTES);
        nxt_ptr   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
        // A done level left over from an earlier job must not complete this one.
        done_rise = core_done & ~core_done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            core_done_q     <= 1'b0;
            gnt             <= '0;
            rsp_valid       <= 1'b0;
            rsp_err         <= 1'b0;
            rsp_id          <= '0;
            rsp_data        <= '0;
            busy            <= 1'b0;
            core_rst_n      <= 1'b0;
            core_start      <= 1'b0;
            core_key        <= '0;
            core_key_length <= '0;
`ifdef RC4_ARB_WATCHDOG_EN
            wd_cnt          <= '0;
`endif
        end else begin
            core_done_q <= core_done;
            gnt         <= '0;
            core_rst_n  <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt    <= NUM_REQ'(1) << win_idx;
                        rsp_id <= ID_W'(win_idx);
                        rr_ptr <= nxt_ptr;
                        busy   <= 1'b1;
                        if (len_bad) begin
                            // Rejected jobs never reach the core.
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            core_key        <= win_key;
                            core_key_length <= win_len;
                            rsp_err         <= 1'b0;
                            state           <= GRANT;
                        end
                    end
                end

                GRANT: begin
                    core_rst_n <= 1'b0;
                    state      <= CLR;
                end

                CLR: begin
                    core_start <= 1'b1;
`ifdef RC4_ARB_WATCHDOG_EN
                    wd_cnt     <= '0;
`endif
                    state      <= RUN;
                end

                RUN: begin
                    if (done_rise) begin
                        rsp_data   <= core_data_out;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        core_start <= 1'b0;
                        state      <= RESP;
                    end
`ifdef RC4_ARB_WATCHDOG_EN
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort a hung core: zero data, error flag, clear the core.
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        core_start <= 1'b0;
                        core_rst_n <= 1'b0;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_job_arbiter.sv
module tb_rc4_job_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int NB       = 16;
    localparam int KW       = NB * 8;
    localparam int ID_W     = 2;
    localparam int CORE_LAT = 6;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*KW-1:0] req_key;
    logic [NUM_REQ*8-1:0]  req_key_length;
    logic [NUM_REQ-1:0]    gnt;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_err;
    logic [KW-1:0]         rsp_data;
    logic                  busy;
    logic                  core_rst_n;
    logic                  core_start;
    logic [KW-1:0]         core_key;
    logic [7:0]            core_key_length;
    logic [KW-1:0]         core_data_out;
    logic                  core_done;

    logic [KW-1:0] key_tab [NUM_REQ];
    logic [7:0]    len_tab [NUM_REQ];
    bit            core_hang;
    int            core_cnt;

    int total;
    int passed;

    rc4_job_arbiter #(
        .NUM_REQ(NUM_REQ), .NUMS_OF_BYTES(NB), .ID_W(ID_W), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_key(req_key),
        .req_key_length(req_key_length), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .busy(busy), .core_rst_n(core_rst_n),
        .core_start(core_start), .core_key(core_key),
        .core_key_length(core_key_length), .core_data_out(core_data_out),
        .core_done(core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_key[r*KW +: KW]        = key_tab[r];
            req_key_length[r*8 +: 8]   = len_tab[r];
        end
    end

    // Reference RC4: KSA followed by NB bytes of PRGA output.
    function automatic logic [KW-1:0] rc4_ks(input logic [KW-1:0] key, input logic [7:0] len);
        int s [256];
        int j, i, t;
        logic [KW-1:0] o;
        o = '0;
        if (len == 0) return o;
        for (int k = 0; k < 256; k++) s[k] = k;
        j = 0;
        for (int k = 0; k < 256; k++) begin
            j = (j + s[k] + int'(key[(k % int'(len))*8 +: 8])) % 256;
            t = s[k]; s[k] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int n = 0; n < NB; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            o[n*8 +: 8] = 8'(s[(s[i] + s[j]) % 256]);
        end
        return o;
    endfunction

    // Behavioural RC4 core: done after CORE_LAT started cycles, held until core reset.
    always @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            core_done     <= 1'b0;
            core_data_out <= '0;
            core_cnt      <= 0;
        end else if (core_start && !core_done && !core_hang) begin
            if (core_cnt == CORE_LAT - 1) begin
                core_done     <= 1'b1;
                core_data_out <= rc4_ks(core_key, core_key_length);
            end
            core_cnt <= core_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_timeout(input string name);
        total++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic int model_winner(input logic [NUM_REQ-1:0] r, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    // Transaction-level model and per-cycle compare.
    typedef struct {
        int            id;
        bit            err;
        bit            badlen;
        logic [KW-1:0] data;
    } job_t;

    job_t q[$];

    initial begin
        int                 m_rr;
        logic [NUM_REQ-1:0] req_s;
        logic [NUM_REQ-1:0] eg;
        bit                 idle_s;
        bit                 hold_s;
        int                 w;
        job_t               j;
        m_rr = 0; req_s = '0; idle_s = 1'b1; hold_s = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_rr = 0; idle_s = 1'b1; hold_s = 1'b0; req_s = req;
                continue;
            end
            chk("gnt_when_idle_and_req", gnt != 0, idle_s && (req_s != 0));
            if (gnt != 0) begin
                w = model_winner(req_s, m_rr);
                if (w < 0) w = 0;
                eg = '0; eg[w] = 1'b1;
                chk("gnt_rr_winner", gnt, eg);
                m_rr     = (w + 1) % NUM_REQ;
                j.id     = w;
                j.badlen = (len_tab[w] == 0) || (int'(len_tab[w]) > NB);
                j.err    = j.badlen || core_hang;
                j.data   = j.err ? '0 : rc4_ks(key_tab[w], len_tab[w]);
                q.push_back(j);
                if (j.badlen) chk("badlen_rsp_immediate", rsp_valid, 1'b1);
            end
            chk("busy", busy, q.size() != 0);
            if (hold_s) chk("rsp_valid_held", rsp_valid, 1'b1);
            if (q.size() == 0) begin
                chk("no_rsp_without_job", rsp_valid, 1'b0);
            end else begin
                if (q[0].badlen) chk("core_start_badlen", core_start, 1'b0);
                if (rsp_valid) begin
                    chk("rsp_id", rsp_id, q[0].id[ID_W-1:0]);
                    chk("rsp_err", rsp_err, q[0].err);
                    chk("rsp_data", rsp_data, q[0].data);
                end
            end
            idle_s = (q.size() == 0);
            hold_s = rsp_valid && !rsp_ready;
            if (rsp_valid && rsp_ready && q.size() != 0) q.delete(0);
            req_s = req;
        end
    end

    task automatic wait_gnt(output int idx);
        idx = -1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (gnt != 0) begin
                idx = onehot_idx(gnt);
                break;
            end
        end
        if (idx < 0) note_timeout("gnt");
    endtask

    task automatic request(input int r, output int idx);
        req[r] = 1'b1;
        wait_gnt(idx);
        if (idx >= 0) req[idx] = 1'b0;
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!got) note_timeout("rsp_valid");
    endtask

    task automatic wait_core_start();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (core_start) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!got) note_timeout("core_start");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int idx, gcount, lowcnt, n;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        total = 0; passed = 0;
        rst_n = 1'b0; req = '0; rsp_ready = 1'b1; core_hang = 1'b0;
        key_tab[0] = 128'h79654B;          // "Key"
        len_tab[0] = 8'd3;
        for (int r = 1; r < NUM_REQ; r++) begin
            key_tab[r] = 128'h1122334455 + KW'(r);
            len_tab[r] = 8'd5;
        end

        // Reset values
        repeat (2) @(posedge clk); #1;
        chk("rst_gnt", gnt, '0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_id", rsp_id, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_rst_n", core_rst_n, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_core_key", core_key, '0);
        chk("rst_core_key_length", core_key_length, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("core_rst_n_after_reset", core_rst_n, 1'b1);

        // 1. Single job with key "Key"
        request(0, idx);
        chk("t1_gnt_idx", idx, 0);
        gcount = 1; lowcnt = 0;
        for (n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (gnt[0]) gcount++;
            if (!core_rst_n) lowcnt++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) note_timeout("t1_rsp");
        chk("t1_gnt_pulses", gcount, 1);
        chk("t1_core_rst_low_cycles", lowcnt, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_rsp_bytes0_8", rsp_data[71:0], 72'hA772CA34B781779FEB);
        @(posedge clk); #1;

        // 2. Round-robin with all requesters; requester 0 submits twice
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(idx);
            chk("t2_grant_order", idx, exp_order[g]);
            if (idx >= 0 && g != 0) req[idx] = 1'b0;
        end
        req = '0;
        wait_rsp();
        repeat (2) @(posedge clk); #1;

        // 3. Bad key lengths on requester 2 (0, then 17)
        len_tab[2] = 8'd0;
        request(2, idx);
        wait_rsp();
        chk("t3a_rsp_id", rsp_id, 2);
        chk("t3a_rsp_err", rsp_err, 1);
        chk("t3a_rsp_data", rsp_data, '0);
        @(posedge clk); #1;
        len_tab[2] = 8'd17;
        request(2, idx);
        wait_rsp();
        chk("t3b_rsp_id", rsp_id, 2);
        chk("t3b_rsp_err", rsp_err, 1);
        chk("t3b_rsp_data", rsp_data, '0);
        @(posedge clk); #1;
        len_tab[2] = 8'd5;

        // 4. Backpressure with key "Wiki"; another request pending meanwhile
        key_tab[1] = 128'h696B6957;
        len_tab[1] = 8'd4;
        rsp_ready  = 1'b0;
        request(1, idx);
        chk("t4_gnt_idx", idx, 1);
        req[3] = 1'b1;
        wait_rsp();
        for (n = 0; n < 20; n++) begin
            chk("t4_hold_valid", rsp_valid, 1'b1);
            chk("t4_hold_bytes0_4", rsp_data[39:0], 40'h416DDB4460);
            chk("t4_no_gnt", gnt, '0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_gnt(idx);
        chk("t4_next_gnt_idx", idx, 3);
        req[3] = 1'b0;
        wait_rsp();
        @(posedge clk); #1;

        // 5. Reset in the middle of RUN
        request(0, idx);
        wait_core_start();
        rst_n = 1'b0;
        #1;
        chk("t5_gnt", gnt, '0);
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        chk("t5_rsp_err", rsp_err, 1'b0);
        chk("t5_rsp_id", rsp_id, '0);
        chk("t5_rsp_data", rsp_data, '0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_core_rst_n", core_rst_n, 1'b0);
        chk("t5_core_start", core_start, 1'b0);
        chk("t5_core_key", core_key, '0);
        chk("t5_core_key_length", core_key_length, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_core_rst_n_release", core_rst_n, 1'b1);
        repeat (3) @(posedge clk); #1;
        req = 4'b1010;
        wait_gnt(idx);
        chk("t5_gnt_after_reset", idx, 1);
        req = '0;
        wait_rsp();
        repeat (4) @(posedge clk); #1;

`ifdef RC4_ARB_WATCHDOG_EN
        // 6. Watchdog abort with a core that never completes
        core_hang = 1'b1;
        request(0, idx);
        wait_core_start();
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) note_timeout("t6_rsp");
        chk("t6_run_cycles", n, 8);
        chk("t6_rsp_err", rsp_err, 1);
        chk("t6_rsp_data", rsp_data, '0);
        chk("t6_core_rst_pulse", core_rst_n, 1'b0);
        @(posedge clk); #1;
        chk("t6_core_rst_release", core_rst_n, 1'b1);
        core_hang = 1'b0;
        repeat (2) @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
